// File: rtl/voice_mixer_n.sv
// N-voice sample mixer: gathers one sample per enabled voice, sums with saturation,
// applies a master arithmetic shift and emits one mixed sample with a valid pulse.
module voice_mixer_n #(
  parameter int NUM_VOICES   = 3,
  parameter int SAMPLE_WIDTH = 16,
  parameter int TIMEOUT      = 63
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_VOICES-1:0]              voice_enable,
  input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] sample_in,
  input  logic [NUM_VOICES-1:0]              sample_ready,
  input  logic [2:0]                         master_shift,
  output logic [SAMPLE_WIDTH-1:0]            mix_out,
  output logic                               mix_valid,
  output logic                               timeout_flag,
  output logic [NUM_VOICES-1:0]              missing_mask,
  output logic                               overrun
);

  localparam int SW   = SAMPLE_WIDTH;
  localparam int SUMW = SW + $clog2(NUM_VOICES);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam logic signed [SUMW-1:0] MAX_VAL = {{(SUMW-SW+1){1'b0}}, {(SW-1){1'b1}}};
  localparam logic signed [SUMW-1:0] MIN_VAL = {{(SUMW-SW+1){1'b1}}, {(SW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COLLECT, SUM} state_t;

  state_t                 state_reg, state_next;
  logic [NUM_VOICES-1:0]  got_reg, got_next;
  logic [NUM_VOICES-1:0]  cap;
  logic [TW-1:0]          timer_reg, timer_next;
  logic                   to_reg, to_next;
  logic                   complete;
  logic signed [SW-1:0]   sample_reg [NUM_VOICES];
  logic signed [SUMW-1:0] contrib [NUM_VOICES];
  logic signed [SUMW-1:0] sum, shifted, sat;

  assign cap      = sample_ready & voice_enable;
  // Completion looks at this edge's captures too, so the last ready moves straight to SUM.
  assign complete = (((got_reg | cap) & voice_enable) == voice_enable) && (voice_enable != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_VOICES; i++) sample_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++)
        if (cap[i]) sample_reg[i] <= sample_in[i*SW +: SW];
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_contrib
      assign contrib[gi] = (got_reg[gi] & voice_enable[gi]) ? SUMW'(sample_reg[gi]) : '0;
    end
  endgenerate

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) sum = sum + contrib[i];
    shifted = sum >>> master_shift;
    if (shifted > MAX_VAL)      sat = MAX_VAL;
    else if (shifted < MIN_VAL) sat = MIN_VAL;
    else                        sat = shifted;
  end

  always_comb begin
    state_next = state_reg;
    got_next   = got_reg;
    timer_next = timer_reg;
    to_next    = to_reg;
    case (state_reg)
      IDLE: begin
        got_next   = cap;
        timer_next = '0;
        to_next    = 1'b0;
        if (cap != '0) state_next = complete ? SUM : COLLECT;
      end
      COLLECT: begin
        got_next   = got_reg | cap;
        timer_next = timer_reg + 1'b1;
        if (voice_enable == '0) begin
          state_next = IDLE;
          got_next   = '0;
        end else if (complete) begin
          state_next = SUM;
        end else if (timer_reg == TW'(TIMEOUT - 1)) begin
          state_next = SUM;
          to_next    = 1'b1;
        end
      end
      SUM: begin
        // Readies landing during SUM open the next frame.
        got_next   = cap;
        timer_next = '0;
        to_next    = 1'b0;
        state_next = (cap != '0) ? COLLECT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      got_reg      <= '0;
      timer_reg    <= '0;
      to_reg       <= 1'b0;
      mix_out      <= '0;
      mix_valid    <= 1'b0;
      timeout_flag <= 1'b0;
      missing_mask <= '0;
      overrun      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      got_reg      <= got_next;
      timer_reg    <= timer_next;
      to_reg       <= to_next;
      mix_valid    <= (state_reg == SUM);
      timeout_flag <= (state_reg == SUM) && to_reg;
      overrun      <= (state_reg == COLLECT) && ((cap & got_reg) != '0);
      if (state_reg == SUM) begin
        mix_out      <= sat[SW-1:0];
        missing_mask <= voice_enable & ~got_reg;
      end
    end
  end

endmodule
